rv32i_alu_rs: RTL and testbench

Reservation station for the integer add/sub functional unit. Accepts renamed instructions from dispatch, holds them until both source operands are available, and captures operand values from the common data bus (CDB). Issues the oldest ready entry to the adder over a valid/ready handshake. Sits between rename/dispatch and the adder; the adder's result later returns on the CDB that wakes this block.

---
 rtl/rv32i_alu_rs.sv | 163 ++++++++++++++++
 tb/tb_rv32i_alu_rs.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_alu_rs.sv
// Reservation station for the integer add/sub unit: compacting age queue.
// Optional o_stall_cnt when RV32I_ALU_RS_STALL_CNT_EN is defined.
package rv32i_pkg;
  localparam int PHYS_REG_FILE_IDX_BW = 6;
  localparam int ROB_DEPTH = 16;
  localparam int RBW = $clog2(ROB_DEPTH);

  typedef logic [PHYS_REG_FILE_IDX_BW-1:0] ptag_t;
  typedef logic [RBW-1:0] rob_idx_t;

  typedef struct packed {
    logic        rdy;
    ptag_t       tag;
    logic [31:0] val;
  } rs_src_t;

  typedef struct packed {
    logic     vld;
    logic     sub;
    rs_src_t  s1;
    rs_src_t  s2;
    ptag_t    dst;
    rob_idx_t rob;
  } rs_entry_t;
endpackage

module rv32i_alu_rs
  import rv32i_pkg::*;
#(
  parameter int RS_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_flush,
  input  logic                  i_disp_vld,
  output logic                  o_disp_rdy,
  input  logic                  i_disp_sub_flag,
  input  logic                  i_disp_src1_rdy,
  input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_disp_src1_tag,
  input  logic [31:0]           i_disp_src1_val,
  input  logic                  i_disp_src2_rdy,
  input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_disp_src2_tag,
  input  logic [31:0]           i_disp_src2_val,
  input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_disp_dst_tag,
  input  logic [RBW-1:0]        i_disp_rob_idx,
  input  logic                  i_cdb_vld,
  input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_cdb_tag,
  input  logic [31:0]           i_cdb_data,
  output logic                  o_iss_vld,
  input  logic                  i_iss_rdy,
  output logic                  o_iss_sub_flag,
  output logic [31:0]           o_iss_a,
  output logic [31:0]           o_iss_b,
  output logic [PHYS_REG_FILE_IDX_BW-1:0] o_iss_dst_tag,
  output logic [RBW-1:0]        o_iss_rob_idx,
`ifdef RV32I_ALU_RS_STALL_CNT_EN
  output logic [31:0]           o_stall_cnt,
`endif
  output logic [$clog2(RS_DEPTH+1)-1:0] o_occupancy
);

  localparam int OW = $clog2(RS_DEPTH+1);
  localparam int IW = $clog2(RS_DEPTH);

  rs_entry_t ent_q [RS_DEPTH];
  rs_entry_t ent_d [RS_DEPTH];
  rs_entry_t ext   [RS_DEPTH+1];
  rs_entry_t nw;
  logic [OW-1:0] occ_q, occ_d, wr_idx;
  logic [IW-1:0] sel_idx;
  logic sel_vld, iss_fire, disp_fire, disp_rdy;

  function automatic rs_src_t wake(input rs_src_t s, input logic v,
                                   input ptag_t t, input logic [31:0] d);
    rs_src_t r;
    r = s;
    if (!s.rdy && v && s.tag == t) begin
      r.rdy = 1'b1;
      r.val = d;
    end
    return r;
  endfunction

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!sel_vld && ent_q[i].vld && ent_q[i].s1.rdy && ent_q[i].s2.rdy) begin
        sel_vld = 1'b1;
        sel_idx = i[IW-1:0];
      end
    end
    iss_fire  = sel_vld & i_iss_rdy;
    disp_rdy  = occ_q < OW'(RS_DEPTH);
    disp_fire = i_disp_vld & disp_rdy;

    // Wake first so entries that shift down keep this cycle's capture
    for (int i = 0; i < RS_DEPTH; i++) begin
      ext[i]    = ent_q[i];
      ext[i].s1 = wake(ent_q[i].s1, i_cdb_vld, i_cdb_tag, i_cdb_data);
      ext[i].s2 = wake(ent_q[i].s2, i_cdb_vld, i_cdb_tag, i_cdb_data);
    end
    ext[RS_DEPTH] = '0;

    nw.vld = 1'b1;
    nw.sub = i_disp_sub_flag;
    nw.s1  = wake({i_disp_src1_rdy, i_disp_src1_tag, i_disp_src1_val},
                  i_cdb_vld, i_cdb_tag, i_cdb_data);
    nw.s2  = wake({i_disp_src2_rdy, i_disp_src2_tag, i_disp_src2_val},
                  i_cdb_vld, i_cdb_tag, i_cdb_data);
    nw.dst = i_disp_dst_tag;
    nw.rob = i_disp_rob_idx;

    wr_idx = occ_q - OW'(iss_fire);
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (iss_fire && i >= int'(sel_idx)) ent_d[i] = ext[i+1];
      else                                ent_d[i] = ext[i];
      if (disp_fire && i == int'(wr_idx)) ent_d[i] = nw;
    end
    occ_d = occ_q + OW'(disp_fire) - OW'(iss_fire);

    if (i_flush) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_d[i] = '0;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
      occ_q <= occ_d;
    end
  end

  assign o_disp_rdy     = disp_rdy;
  assign o_occupancy    = occ_q;
  assign o_iss_vld      = sel_vld;
  assign o_iss_sub_flag = sel_vld ? ent_q[sel_idx].sub    : 1'b0;
  assign o_iss_a        = sel_vld ? ent_q[sel_idx].s1.val : '0;
  assign o_iss_b        = sel_vld ? ent_q[sel_idx].s2.val : '0;
  assign o_iss_dst_tag  = sel_vld ? ent_q[sel_idx].dst    : '0;
  assign o_iss_rob_idx  = sel_vld ? ent_q[sel_idx].rob    : '0;

`ifdef RV32I_ALU_RS_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q + 32'(sel_vld & ~i_iss_rdy);
    if (i_flush) stall_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rv32i_alu_rs.sv
// Bench for rv32i_alu_rs: directed steps then random traffic vs a queue model.
// Checks o_stall_cnt when RV32I_ALU_RS_STALL_CNT_EN is defined.
module tb_rv32i_alu_rs;
  import rv32i_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 0, rstn = 0, i_flush = 0;
  logic i_disp_vld = 0, o_disp_rdy, i_disp_sub_flag = 0;
  logic i_disp_src1_rdy = 0, i_disp_src2_rdy = 0;
  ptag_t i_disp_src1_tag = '0, i_disp_src2_tag = '0, i_disp_dst_tag = '0;
  logic [31:0] i_disp_src1_val = '0, i_disp_src2_val = '0;
  rob_idx_t i_disp_rob_idx = '0;
  logic i_cdb_vld = 0;
  ptag_t i_cdb_tag = '0;
  logic [31:0] i_cdb_data = '0;
  logic o_iss_vld, i_iss_rdy = 0, o_iss_sub_flag;
  logic [31:0] o_iss_a, o_iss_b;
  ptag_t o_iss_dst_tag;
  rob_idx_t o_iss_rob_idx;
  logic [$clog2(DEPTH+1)-1:0] o_occupancy;
`ifdef RV32I_ALU_RS_STALL_CNT_EN
  logic [31:0] o_stall_cnt;
`endif

  rv32i_alu_rs #(.RS_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .i_flush(i_flush),
    .i_disp_vld(i_disp_vld), .o_disp_rdy(o_disp_rdy),
    .i_disp_sub_flag(i_disp_sub_flag),
    .i_disp_src1_rdy(i_disp_src1_rdy), .i_disp_src1_tag(i_disp_src1_tag),
    .i_disp_src1_val(i_disp_src1_val),
    .i_disp_src2_rdy(i_disp_src2_rdy), .i_disp_src2_tag(i_disp_src2_tag),
    .i_disp_src2_val(i_disp_src2_val),
    .i_disp_dst_tag(i_disp_dst_tag), .i_disp_rob_idx(i_disp_rob_idx),
    .i_cdb_vld(i_cdb_vld), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
    .o_iss_vld(o_iss_vld), .i_iss_rdy(i_iss_rdy),
    .o_iss_sub_flag(o_iss_sub_flag), .o_iss_a(o_iss_a), .o_iss_b(o_iss_b),
    .o_iss_dst_tag(o_iss_dst_tag), .o_iss_rob_idx(o_iss_rob_idx),
`ifdef RV32I_ALU_RS_STALL_CNT_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .o_occupancy(o_occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sub;
    bit          r1;
    ptag_t       t1;
    logic [31:0] v1;
    bit          r2;
    ptag_t       t2;
    logic [31:0] v2;
    ptag_t       dst;
    rob_idx_t    rob;
  } m_t;

  m_t q[$];
  int unsigned m_stall = 0;
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    i_disp_vld = 0;
    i_cdb_vld  = 0;
    i_flush    = 0;
  endtask

  task automatic disp(input bit sub, input bit r1, input ptag_t t1,
                      input logic [31:0] v1, input bit r2, input ptag_t t2,
                      input logic [31:0] v2, input ptag_t dst,
                      input rob_idx_t rob);
    i_disp_vld = 1;
    i_disp_sub_flag = sub;
    i_disp_src1_rdy = r1; i_disp_src1_tag = t1; i_disp_src1_val = v1;
    i_disp_src2_rdy = r2; i_disp_src2_tag = t2; i_disp_src2_val = v2;
    i_disp_dst_tag = dst; i_disp_rob_idx = rob;
  endtask

  task automatic cdb(input ptag_t t, input logic [31:0] d);
    i_cdb_vld = 1; i_cdb_tag = t; i_cdb_data = d;
  endtask

  // Compare outputs against the model, advance model and one clock
  task automatic step();
    int sel;
    bit full;
    m_t n;
    sel = -1;
    foreach (q[i]) if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
    full = q.size() >= DEPTH;
    check("occupancy", 32'(o_occupancy), 32'(q.size()));
    check("iss_vld", 32'(o_iss_vld), 32'(sel >= 0));
    check("disp_rdy", 32'(o_disp_rdy), 32'(!full));
    if (sel >= 0) begin
      check("iss_a", o_iss_a, q[sel].v1);
      check("iss_b", o_iss_b, q[sel].v2);
      check("iss_sub", 32'(o_iss_sub_flag), 32'(q[sel].sub));
      check("iss_dst", 32'(o_iss_dst_tag), 32'(q[sel].dst));
      check("iss_rob", 32'(o_iss_rob_idx), 32'(q[sel].rob));
    end
`ifdef RV32I_ALU_RS_STALL_CNT_EN
    check("stall_cnt", o_stall_cnt, m_stall);
`endif
    if (i_flush) begin
      q.delete();
      m_stall = 0;
    end else begin
      if (sel >= 0 && !i_iss_rdy) m_stall++;
      if (i_cdb_vld) foreach (q[i]) begin
        if (!q[i].r1 && q[i].t1 == i_cdb_tag) begin
          q[i].r1 = 1; q[i].v1 = i_cdb_data;
        end
        if (!q[i].r2 && q[i].t2 == i_cdb_tag) begin
          q[i].r2 = 1; q[i].v2 = i_cdb_data;
        end
      end
      if (sel >= 0 && i_iss_rdy) q.delete(sel);
      if (i_disp_vld && !full) begin
        n.sub = i_disp_sub_flag;
        n.r1 = i_disp_src1_rdy; n.t1 = i_disp_src1_tag; n.v1 = i_disp_src1_val;
        n.r2 = i_disp_src2_rdy; n.t2 = i_disp_src2_tag; n.v2 = i_disp_src2_val;
        n.dst = i_disp_dst_tag; n.rob = i_disp_rob_idx;
        if (i_cdb_vld && !n.r1 && n.t1 == i_cdb_tag) begin
          n.r1 = 1; n.v1 = i_cdb_data;
        end
        if (i_cdb_vld && !n.r2 && n.t2 == i_cdb_tag) begin
          n.r2 = 1; n.v2 = i_cdb_data;
        end
        q.push_back(n);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check("rst_occ", 32'(o_occupancy), 0);
    check("rst_iss_vld", 32'(o_iss_vld), 0);
    check("rst_disp_rdy", 32'(o_disp_rdy), 1);
    check("rst_iss_a", o_iss_a, 0);
    check("rst_iss_dst", 32'(o_iss_dst_tag), 0);
    rstn = 1;
    @(negedge clk);

    // Both ready: issue one cycle later
    disp(1, 1, 0, 5, 1, 0, 3, 7, 2);
    step();
    clr(); i_iss_rdy = 1;
    check("t1_vld", 32'(o_iss_vld), 1);
    check("t1_a", o_iss_a, 5);
    check("t1_b", o_iss_b, 3);
    check("t1_sub", 32'(o_iss_sub_flag), 1);
    check("t1_dst", 32'(o_iss_dst_tag), 7);
    check("t1_rob", 32'(o_iss_rob_idx), 2);
    step();
    check("t1_occ", 32'(o_occupancy), 0);
    step();

    // CDB wakeup
    disp(0, 0, 9, 0, 1, 0, 1, 8, 3);
    step();
    clr(); cdb(9, 32'hDEADBEEF);
    check("t2_wait", 32'(o_iss_vld), 0);
    step();
    clr();
    check("t2_vld", 32'(o_iss_vld), 1);
    check("t2_a", o_iss_a, 32'hDEADBEEF);
    step();

    // Dispatch bypass
    disp(0, 1, 0, 11, 0, 4, 0, 9, 4);
    cdb(4, 42);
    step();
    clr();
    check("t3_vld", 32'(o_iss_vld), 1);
    check("t3_b", o_iss_b, 42);
    step();

    // Stall for three cycles
    i_flush = 1; step(); clr();
    i_iss_rdy = 0;
    disp(0, 1, 0, 32'h1234, 1, 0, 32'h55, 5, 5);
    step(); clr();
    repeat (3) begin
      check("t4_hold_a", o_iss_a, 32'h1234);
      check("t4_hold_dst", 32'(o_iss_dst_tag), 5);
      step();
    end
`ifdef RV32I_ALU_RS_STALL_CNT_EN
    check("t4_stall3", o_stall_cnt, 3);
`endif
    i_iss_rdy = 1;
    step();

    // Fill, then age-ordered issue
    i_iss_rdy = 0;
    disp(0, 0, 10, 0, 1, 0, 1, 20, 0); step();
    disp(0, 0, 10, 0, 1, 0, 2, 21, 1); step();
    disp(0, 1, 0, 3, 1, 0, 3, 22, 2); step();
    disp(0, 0, 12, 0, 1, 0, 4, 23, 3); step();
    disp(0, 1, 0, 9, 1, 0, 9, 24, 4);
    i_iss_rdy = 1;
    check("t5_full", 32'(o_disp_rdy), 0);
    check("t5_first", 32'(o_iss_dst_tag), 22);
    step();
    clr();
    check("t5_rdy_back", 32'(o_disp_rdy), 1);
    check("t5_occ3", 32'(o_occupancy), 3);
    cdb(10, 100);
    step();
    clr();
    check("t5_second", 32'(o_iss_dst_tag), 20);
    step();
    check("t5_third", 32'(o_iss_dst_tag), 21);
    step();

    // Flush beats dispatch and issue
    i_iss_rdy = 0;
    disp(1, 1, 0, 1, 1, 0, 2, 30, 6); step();
    disp(1, 1, 0, 3, 1, 0, 4, 31, 7); step();
    check("t6_occ3", 32'(o_occupancy), 3);
    disp(0, 1, 0, 5, 1, 0, 6, 32, 8);
    i_iss_rdy = 1; i_flush = 1;
    step();
    clr();
    check("t6_occ0", 32'(o_occupancy), 0);
    check("t6_vld0", 32'(o_iss_vld), 0);
    step();

    // Async reset mid-operation
    i_iss_rdy = 0;
    disp(0, 1, 0, 7, 1, 0, 8, 33, 9); step();
    disp(0, 0, 3, 0, 1, 0, 8, 34, 9); step();
    clr();
    rstn = 0;
    #1;
    check("t7_occ0", 32'(o_occupancy), 0);
    check("t7_vld0", 32'(o_iss_vld), 0);
    check("t7_a0", o_iss_a, 0);
    q.delete();
    m_stall = 0;
    #1 rstn = 1;
    @(negedge clk);
    step();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      clr();
      if ($urandom_range(0, 2) != 0)
        disp(1'($urandom), 1'($urandom), ptag_t'($urandom_range(0, 7)),
             $urandom, 1'($urandom), ptag_t'($urandom_range(0, 7)),
             $urandom, ptag_t'($urandom), rob_idx_t'($urandom));
      if ($urandom_range(0, 1) != 0)
        cdb(ptag_t'($urandom_range(0, 7)), $urandom);
      i_iss_rdy = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 60) == 0);
      step();
    end
    clr();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
